// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: digit index type, anode
// one-cold patterns, blanking code and the active-low hex font.
package seg_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    localparam logic [7:0] ANODE_DIG0 = 8'hFE;
    localparam logic [7:0] ANODE_DIG1 = 8'hFD;
    localparam logic [7:0] ANODE_DIG2 = 8'hFB;
    localparam logic [7:0] ANODE_DIG3 = 8'hF7;

    // Active-low {g,f,e,d,c,b,a}; the first listed entry is glyph F.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] anode_pattern(input digit_idx_t idx);
        logic [7:0] pat;
        pat = ANODE_DIG0;
        case (idx)
            2'd0: pat = ANODE_DIG0;
            2'd1: pat = ANODE_DIG1;
            2'd2: pat = ANODE_DIG2;
            2'd3: pat = ANODE_DIG3;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decode ({g..a}).
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit seven-segment scan scheduler with a frame-synchronous double buffer.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
`ifdef SEG_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic        load_ready,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  anode,
    output logic [7:0]  cathode
);

    localparam int PW = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("seg_scan_scheduler: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [PW-1:0] prescaler;
    digit_idx_t    idx;
    digit_idx_t    idx_next;
    logic          pending;
    logic [15:0]   active_value;
    logic [3:0]    active_dp;
    logic [15:0]   shadow_value;
    logic [3:0]    shadow_dp;

    logic          tc;
    logic          wrap;
    logic          commit;
    logic          capture;
    logic [15:0]   value_next;
    logic [3:0]    dp_next;
    logic [3:0]    nibble;
    logic          dp_bit;
    logic [6:0]    segs;
    logic          blanked;

    assign tc       = (prescaler == PW'(REFRESH_DIV - 1));
    assign wrap     = tc && (idx == 2'd3);
    assign commit   = wrap && pending;
    assign capture  = load && !pending;
    assign idx_next = tc ? idx + 2'd1 : idx;

    assign load_ready  = ~pending;
    assign load_ack    = commit;
    assign frame_start = wrap;

    // Decode from the post-commit buffer so the first digit of a new frame is never stale.
    always_comb begin
        value_next = active_value;
        dp_next    = active_dp;
        if (commit) begin
            value_next = shadow_value;
            dp_next    = shadow_dp;
        end
        nibble = value_next[{idx_next, 2'b00} +: 4];
        dp_bit = dp_next[idx_next];
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .segs   (segs)
    );

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          blink_on_next;
    logic          blink_cnt_tc;

    assign blink_cnt_tc  = (blink_cnt == BW'(BLINK_FRAMES - 1));
    assign blink_on_next = (wrap && blink_cnt_tc) ? ~blink_on : blink_on;
    assign blanked       = !digit_en[idx_next] || (!blink_on_next && blink_mask[idx_next]);

    always_ff @(posedge clkin) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (wrap) begin
            blink_cnt <= blink_cnt_tc ? '0 : blink_cnt + BW'(1);
            blink_on  <= blink_on_next;
        end
    end
`else
    assign blanked = !digit_en[idx_next];
`endif

    always_ff @(posedge clkin) begin
        if (reset) begin
            prescaler    <= '0;
            idx          <= 2'd0;
            pending      <= 1'b0;
            active_value <= '0;
            active_dp    <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            anode        <= SEG_BLANK;
            cathode      <= SEG_BLANK;
        end else begin
            prescaler <= tc ? '0 : prescaler + PW'(1);
            idx       <= idx_next;
            // commit needs pending=1 and capture needs pending=0, so they never coincide.
            if (commit) begin
                active_value <= shadow_value;
                active_dp    <= shadow_dp;
                pending      <= 1'b0;
            end else if (capture) begin
                shadow_value <= value;
                shadow_dp    <= dp;
                pending      <= 1'b1;
            end
            anode   <= blanked ? SEG_BLANK : anode_pattern(idx_next);
            cathode <= blanked ? SEG_BLANK : {~dp_bit, segs};
        end
    end

endmodule
